axi_mem_rd_slave: RTL
=====================

AXI_MEM_RD_SLAVE -- requirements
Module: axi_mem_rd_slave

Interface
REQ-001 The block SHALL have parameter AXI_DATA_WIDTH, default 64, giving the R data width in bits.
REQ-002 The block SHALL have parameter AXI_ADDR_WIDTH, default 32, giving the AR address width.
REQ-003 The block SHALL have parameter AXI_ID_WIDTH, default 8, giving the ARID/RID width.
REQ-004 The block SHALL have parameter MEM_DEPTH, default 1024, giving the internal memory depth in words.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; every register is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: the reset, which is synchronous and active-high.
REQ-007 The block SHALL have port s_axi_arid, input, width AXI_ID_WIDTH: the read burst ID.
REQ-008 The block SHALL have port s_axi_araddr, input, width AXI_ADDR_WIDTH: the byte start address.
REQ-009 The block SHALL have port s_axi_arlen, input, width 8: the beat count minus 1.
REQ-010 The block SHALL have port s_axi_arsize, input, width 3: log2 of the bytes per beat.
REQ-011 The block SHALL have port s_axi_arburst, input, width 2: the burst type.
REQ-012 The block SHALL have port s_axi_arvalid, input, width 1: AR request valid.
REQ-013 The block SHALL have port s_axi_arready, output, width 1: AR accept.
REQ-014 The block SHALL have port s_axi_rid, output, width AXI_ID_WIDTH: the returned ID.
REQ-015 The block SHALL have port s_axi_rdata, output, width AXI_DATA_WIDTH: the read data.
REQ-016 The block SHALL have port s_axi_rresp, output, width 2: the per-beat response code.
REQ-017 The block SHALL have port s_axi_rlast, output, width 1: marks the final beat of a burst.
REQ-018 The block SHALL have port s_axi_rvalid, output, width 1: R beat valid.
REQ-019 The block SHALL have port s_axi_rready, input, width 1: R beat accept.
REQ-020 The block SHALL have port mem_we, input, width 1: preload write enable.
REQ-021 The block SHALL have port mem_waddr, input, width $clog2(MEM_DEPTH): the preload word index.
REQ-022 The block SHALL have port mem_wdata, input, width AXI_DATA_WIDTH: the preload data.

Function
REQ-023 The block SHALL implement an FSM with states IDLE and BURST and SHALL hold at most one outstanding burst.
REQ-024 s_axi_arready SHALL equal 1 in IDLE and 0 in BURST, with no combinational path from arvalid.
REQ-025 On an AR handshake in cycle N, the block SHALL:
- latch arid, arburst and arsize;
- set the word pointer to araddr >> $clog2(AXI_DATA_WIDTH/8);
- set the remaining-beat count to arlen+1;
- enter BURST.
REQ-026 In cycle N+1 the block SHALL assert s_axi_rvalid with beat 0; the ID SHALL be carried on s_axi_rid for every beat.
REQ-027 While rvalid=1 and rready=0, rdata, rresp, rlast and rid SHALL hold stable.
REQ-028 On each R handshake the next beat SHALL be presented in the following cycle, giving one beat per cycle while rready=1.
REQ-029 For INCR bursts the pointer SHALL increment by 1 per beat; for FIXED bursts the pointer SHALL not change.
REQ-030 s_axi_rlast SHALL be 1 only on beat arlen.
REQ-031 After the rlast handshake the block SHALL deassert rvalid and return to IDLE, so that arready=1 in the next cycle.
REQ-032 A beat SHALL return rresp=OKAY (2'b00) with rdata = mem[pointer] when the pointer is less than MEM_DEPTH; otherwise it SHALL return SLVERR (2'b10) with rdata=0.
REQ-033 Every beat SHALL return SLVERR with rdata=0 when arburst=WRAP (2'b10) or reserved, or when arsize != $clog2(AXI_DATA_WIDTH/8); the beat count and rlast SHALL be unaffected.
REQ-034 An arlen=0 request SHALL produce one beat with rlast=1.
REQ-035 mem_we SHALL write mem[mem_waddr] at any time, including during BURST.
REQ-036 A beat loaded in the same cycle as a preload write to the same index SHALL return the old data.
REQ-037 The pointer SHALL not wrap; INCR beats crossing MEM_DEPTH SHALL follow REQ-032.

Reset
REQ-038 While rst=1 the block SHALL force IDLE, arready=1 (taking effect from the first cycle after rst deasserts), rvalid=0, rlast=0, rresp=0, rid=0 and rdata=0.
REQ-039 Reset asserted during BURST SHALL abandon the burst with no further beats; memory contents SHALL be preserved.

Verification
REQ-040 Preload mem[0..3]=0x10..0x13, then AR addr 0x0, len 3, INCR, size 3, id 0x5, with rready=1 -> 4 beats on consecutive cycles with data 0x10..0x13, rid 0x5, rlast on beat 3, OKAY; arready=1 again one cycle after rlast.
REQ-041 Same burst with rready toggling 1/0 -> every beat is held stable while stalled, with no loss or duplication.
REQ-042 AR addr 0x1FF0, len 3, INCR, MEM_DEPTH 1024 -> beats 0-1 are OKAY with mem[1022..1023], and beats 2-3 are SLVERR with data 0.
REQ-043 AR with burst WRAP, len 1 -> 2 beats SLVERR with data 0 and rlast on beat 1; AR with FIXED, len 2, addr 0x8 -> 3 beats all equal to mem[1].
REQ-044 Assert rst after beat 1 of a len-7 burst -> rvalid=0 the next cycle and arready=1 after release; a new burst then returns the correct data.

Source files
------------

// File: rtl/axi_mem_rd_slave.sv
// AXI4 read-only slave backed by an internal word memory.
// One outstanding burst at a time; beats are produced from registered outputs,
// one per cycle while the master keeps rready high. A side preload port writes
// the memory at any time.
module axi_mem_rd_slave #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned MEM_DEPTH      = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    // AR channel
    input  logic [AXI_ID_WIDTH-1:0]      s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    // R channel
    output logic [AXI_ID_WIDTH-1:0]      s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]    s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    // Preload port
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [AXI_DATA_WIDTH-1:0]    mem_wdata
);

    localparam int unsigned BYTES    = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG = $clog2(BYTES);
    localparam int unsigned MEM_AW   = $clog2(MEM_DEPTH);
    // One extra bit so an INCR burst running past the top never wraps back in range.
    localparam int unsigned PTR_W    = AXI_ADDR_WIDTH + 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {StIdle, StBurst} state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                    state_q;
    logic                      arready_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    logic [1:0]                rresp_q;
    logic [AXI_ID_WIDTH-1:0]   rid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [PTR_W-1:0]          ptr_q;   // word index of the next beat to load
    logic [7:0]                rem_q;   // beats still to be loaded after the one on the bus
    logic                      err_q;   // whole burst answers SLVERR
    logic                      incr_q;

    logic                      ar_hs;
    logic                      r_hs;
    logic                      ar_err;
    logic [PTR_W-1:0]          load_ptr;
    logic                      load_err;
    logic                      load_incr;
    logic                      load_ok;
    logic [AXI_DATA_WIDTH-1:0] load_data;

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

    // Select the source (new request or running burst) of the beat loaded this cycle.
    always_comb begin
        ar_hs     = arready_q & s_axi_arvalid;
        r_hs      = rvalid_q & s_axi_rready;
        ar_err    = !((s_axi_arburst == BURST_FIXED) || (s_axi_arburst == BURST_INCR)) ||
                    (s_axi_arsize != 3'(SIZE_LOG));
        load_ptr  = ar_hs ? {1'b0, (s_axi_araddr >> SIZE_LOG)} : ptr_q;
        load_err  = ar_hs ? ar_err : err_q;
        load_incr = ar_hs ? (s_axi_arburst == BURST_INCR) : incr_q;
        load_ok   = !load_err && (load_ptr < PTR_W'(MEM_DEPTH));
        // Read happens before this edge's preload write lands, so a same-index write
        // in the load cycle returns the old word.
        load_data = load_ok ? mem[load_ptr[MEM_AW-1:0]] : '0;
    end

    // Preload write port; not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Burst FSM with registered AR/R outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            incr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ar_hs) begin
                        rid_q     <= s_axi_arid;
                        err_q     <= ar_err;
                        incr_q    <= load_incr;
                        ptr_q     <= load_ptr + PTR_W'(load_incr);
                        rem_q     <= s_axi_arlen;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= load_data;
                        rresp_q   <= load_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast_q   <= (s_axi_arlen == 8'd0);
                        arready_q <= 1'b0;
                        state_q   <= StBurst;
                    end
                end
                StBurst: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            rdata_q <= load_data;
                            rresp_q <= load_ok ? RESP_OKAY : RESP_SLVERR;
                            rlast_q <= (rem_q == 8'd1);
                            rem_q   <= rem_q - 8'd1;
                            ptr_q   <= load_ptr + PTR_W'(load_incr);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
